// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to single APB SETUP->ACCESS transfer.
// Optional ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   PCLK, PRESETn                     clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata  upstream command handshake
//   rsp_valid/rdata/err               one-cycle completion pulse
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request to slave
//   PRDATA/PREADY                     APB response from slave
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic done;
  logic tmo;

  assign accept = (state == S_IDLE) && cmd_valid;
  // PREADY only counts in ACCESS; a stale high level elsewhere is ignored.
  assign done   = (state == S_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (state == S_SETUP) begin
      cnt <= '0;
    end else if ((state == S_ACCESS) && !PREADY) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires on the last allowed wait cycle; PREADY in that cycle wins.
  assign tmo = (state == S_ACCESS) && !PREADY &&
               (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (cmd_valid) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (done || tmo) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // cmd_ready stays low while reset is held, high in IDLE after release.
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state)
      S_IDLE:   cmd_ready = PRESETn;
      S_SETUP:  PSEL      = 1'b1;
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || tmo;
      rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
      rsp_err   <= tmo;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed stimulus, queued expectations,
// negedge monitor comparing bus and responses against the queues.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  logic       stub = 1'b0;
  logic       pready_stub = 1'b0;
  logic [7:0] prdata_stub = '0;
  logic       pready_rf;
  logic [7:0] prdata_rf;
  logic [7:0] mem [16];

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W(8),
    .DATA_W(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  // Register-file slave: PREADY registered from PSEL&&PENABLE.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready_rf <= 1'b0;
      prdata_rf <= '0;
    end else begin
      pready_rf <= PSEL && PENABLE && !pready_rf;
      if (PSEL && PENABLE && !pready_rf) begin
        if (PWRITE) begin
          mem[PADDR[3:0]] <= PWDATA;
          prdata_rf <= '0;
        end else begin
          prdata_rf <= mem[PADDR[3:0]];
        end
      end
    end
  end

  assign PREADY = stub ? pready_stub : pready_rf;
  assign PRDATA = stub ? prdata_stub : prdata_rf;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } txn_t;

  txn_t exp_q[$];
  txn_t bus_q[$];
  int   acc_q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: bus stability, busy handshake, response scoreboard.
  always @(negedge PCLK) begin
    txn_t t;
    int   a;
    if (PRESETn) begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
      if (PSEL) begin
        if (bus_q.size() == 0) begin
          chk("psel_unexpected", 1, 0);
        end else begin
          chk("bus_pwrite", PWRITE, bus_q[0].wr);
          chk("bus_paddr", PADDR, bus_q[0].addr);
          chk("bus_pwdata", PWDATA, bus_q[0].wdata);
          chk("ready_low_busy", cmd_ready, 0);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          t = exp_q.pop_front();
          a = acc_q.pop_front();
          if (bus_q.size() > 0) void'(bus_q.pop_front());
          chk("rsp_rdata", rsp_rdata, t.rdata);
          chk("rsp_err", rsp_err, t.err);
          chk("rsp_latency", cyc - a, t.lat);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rdata,
                       input logic err, input int lat, output int acc);
    txn_t t;
    int   n;
    t = '{wr, addr, wdata, rdata, err, lat};
    exp_q.push_back(t);
    bus_q.push_back(t);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    acc = -1;
    forever begin
      @(negedge PCLK);
      if (cmd_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [3:0] k;
    k = 4'(i);
    return {k, ~k};
  endfunction

  initial begin
    int a;
    int prev;
    #1 PRESETn = 1'b0;
    #1;
    chk("reset_outputs",
        {cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE,
         PWRITE, PADDR, PWDATA}, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    #1;
    chk("ready_after_reset", cmd_ready, 1);
    chk("idle_outputs",
        {rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE}, 0);
    @(posedge PCLK);
    #1;

    // write then read back
    issue(1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 3, a);
    issue(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 3, a);
    drain();

    // back-to-back sweep; accept every 4 cycles
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 8'(i), pat(i), 8'h00, 1'b0, 3, a);
      if (prev >= 0) chk("b2b_spacing", a - prev, 4);
      prev = a;
    end
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 8'(i), 8'h00, pat(i), 1'b0, 3, a);
      chk("b2b_spacing", a - prev, 4);
      prev = a;
    end
    drain();

    // valid while busy is not accepted
    issue(1'b1, 8'h07, 8'h3E, 8'h00, 1'b0, 3, a);
    repeat (3) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'hEE;
      cmd_wdata = 8'h99;
      @(negedge PCLK);
      chk("busy_no_accept", cmd_ready, 0);
      @(posedge PCLK);
      #1;
    end
    cmd_valid = 1'b0;
    drain();
    issue(1'b0, 8'h07, 8'h00, 8'h3E, 1'b0, 3, a);
    drain();

    // reset during ACCESS of a write
    issue(1'b1, 8'h05, 8'h77, 8'h00, 1'b0, 3, a);
    @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    exp_q.delete();
    bus_q.delete();
    acc_q.delete();
    #1;
    chk("reset_mid_access",
        {cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE,
         PWRITE, PADDR, PWDATA}, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      chk("no_rsp_after_reset", {rsp_valid, PSEL}, 0);
    end
    @(posedge PCLK);
    #1;
    issue(1'b1, 8'h05, 8'h3C, 8'h00, 1'b0, 3, a);
    issue(1'b0, 8'h05, 8'h00, 8'h3C, 1'b0, 3, a);
    drain();

    // wait states, stale PREADY during SETUP
    stub = 1'b1;
    pready_stub = 1'b1;
    prdata_stub = 8'hEE;
    issue(1'b0, 8'h09, 8'h00, 8'h5C, 1'b0, 5, a);
    @(posedge PCLK);
    #1 pready_stub = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    pready_stub = 1'b1;
    prdata_stub = 8'h5C;
    issue(1'b1, 8'h0A, 8'h11, 8'h00, 1'b0, 3, a);
    @(posedge PCLK);
    #1 pready_stub = 1'b0;
    @(posedge PCLK);
    #1 pready_stub = 1'b1;
    drain();

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY never arrives: timeout after 16 ACCESS cycles
    pready_stub = 1'b0;
    prdata_stub = 8'hFF;
    issue(1'b0, 8'h02, 8'h00, 8'h00, 1'b1, 17, a);
    drain();
`else
    // long wait completes normally without a timeout
    pready_stub = 1'b0;
    prdata_stub = 8'h42;
    issue(1'b0, 8'h02, 8'h00, 8'h42, 1'b0, 22, a);
    repeat (21) @(posedge PCLK);
    #1 pready_stub = 1'b1;
    drain();
`endif
    stub = 1'b0;
    repeat (3) @(posedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
